// File: rtl/ssio_ddr_in_deser_pkg.sv
// rtl/ssio_ddr_in_deser_pkg.sv - shared widths and mode encoding for the DDR input deserialiser
//
// Purpose: word width, lane buffer capacity and buffer count width derived from
// RATIO, plus the DDR/SDR mode encoding.
package ssio_ddr_in_deser_pkg;

    typedef enum logic {
        MODE_DDR = 1'b0,
        MODE_SDR = 1'b1
    } ssio_mode_e;

    // Bits per lane word: two bits per clock over RATIO clocks.
    function automatic int word_w(input int ratio);
        return 2 * ratio;
    endfunction

    // Lane buffer capacity in bits.
    function automatic int cap_w(input int ratio);
        return 2 * word_w(ratio);
    endfunction

    // Width of a count that spans 0..capacity inclusive.
    function automatic int cnt_w(input int ratio);
        return $clog2(cap_w(ratio) + 1);
    endfunction

endpackage

// File: rtl/bsg_link_iddr_phy.sv
// rtl/bsg_link_iddr_phy.sv - DDR input capture cell producing a rising/falling bit pair
//
// Purpose: samples each data bit on both clock edges and presents them as a pair.
// Ports:
//   clk_i     forwarded receive clock
//   data_i    pad data, width_p bits
//   data_r_o  {falling-edge bits, rising-edge bits}; the low half is the older bit
module bsg_link_iddr_phy #(
    parameter int width_p = 1
) (
    input  logic                   clk_i,
    input  logic [width_p-1:0]     data_i,
    output logic [2*width_p-1:0]   data_r_o
);

    logic [width_p-1:0] rise_q;
    logic [width_p-1:0] fall_q;

    always_ff @(posedge clk_i) begin
        rise_q <= data_i;
    end

    always_ff @(negedge clk_i) begin
        fall_q <= data_i;
    end

    // Both halves are stable from the falling edge until the next rising edge,
    // which is where the consumer samples the pair.
    assign data_r_o = {fall_q, rise_q};

endmodule

// File: rtl/ssio_ddr_lane_buf.sv
// rtl/ssio_ddr_lane_buf.sv - per-lane bit buffer with slip-aware append and W-bit pop
//
// Purpose: collects one lane's bits (oldest at bit 0), reports when a full word
// is available after this cycle's append and removes it when told to pop.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   q1_i, q2_i      rising-edge (older) and falling-edge bits for this cycle
//   sdr_mode_i      1 = take q1 only
//   bitslip_i       drop one bit this cycle
//   flush_i         discard buffer contents and this cycle's bits
//   pop_i           remove the oldest W bits this cycle
//   ready_o         post-append count >= W
//   word_o          oldest W bits of the post-append buffer
//   ovf_o           this cycle's append lost bits to a full buffer
module ssio_ddr_lane_buf
    import ssio_ddr_in_deser_pkg::*;
#(
    parameter int RATIO = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 q1_i,
    input  logic                 q2_i,
    input  logic                 sdr_mode_i,
    input  logic                 bitslip_i,
    input  logic                 flush_i,
    input  logic                 pop_i,
    output logic                 ready_o,
    output logic [2*RATIO-1:0]   word_o,
    output logic                 ovf_o
);

    localparam int W   = word_w(RATIO);
    localparam int CAP = cap_w(RATIO);
    localparam int CW  = cnt_w(RATIO);

    logic [CAP-1:0] buf_q;
    logic [CAP-1:0] buf_app;
    logic [CAP-1:0] buf_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_app;
    logic [CW-1:0]  cnt_d;
    logic [CW:0]    cnt_sum;
    logic [1:0]     app_bits;
    logic [1:0]     app_n;

    // Bits to append, packed oldest-first from bit 0, unused positions zero.
    always_comb begin
        app_bits = 2'b00;
        app_n    = 2'd0;
        if (sdr_mode_i == MODE_SDR) begin
            if (!bitslip_i) begin
                app_bits = {1'b0, q1_i};
                app_n    = 2'd1;
            end
        end else if (bitslip_i) begin
            app_bits = {1'b0, q2_i};
            app_n    = 2'd1;
        end else begin
            app_bits = {q2_i, q1_i};
            app_n    = 2'd2;
        end
    end

    // Buffer positions at and above the count are always zero, so an append
    // is an OR at the count offset; bits shifted past CAP are the dropped excess.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CW+1)'(app_n);
        ovf_o   = 1'b0;
        if (flush_i) begin
            buf_app = '0;
            cnt_app = '0;
        end else begin
            buf_app = buf_q | (CAP'(app_bits) << cnt_q);
            if (cnt_sum > (CW+1)'(CAP)) begin
                cnt_app = CW'(CAP);
                ovf_o   = 1'b1;
            end else begin
                cnt_app = cnt_sum[CW-1:0];
            end
        end
    end

    assign ready_o = (cnt_app >= CW'(W));
    assign word_o  = buf_app[W-1:0];

    always_comb begin
        if (pop_i) begin
            buf_d = buf_app >> W;
            cnt_d = cnt_app - CW'(W);
        end else begin
            buf_d = buf_app;
            cnt_d = cnt_app;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssio_ddr_in_deser.sv
// rtl/ssio_ddr_in_deser.sv - multi-lane source-synchronous DDR input deserialiser
//
// Purpose: captures WIDTH DDR lanes, assembles each into 2*RATIO-bit words and
// emits all lanes together on a single valid pulse.
// Ports:
//   clk_i       forwarded receive clock
//   reset_i     synchronous active-high reset
//   ddr_i       pad data, one bit per lane
//   sdr_mode_i  0 = DDR, 1 = SDR (rising-edge bit only)
//   bitslip_i   per-lane one-bit slip request
//   data_o      lane n word at data_o[n*W +: W], bit 0 oldest; held between pulses
//   valid_o     one-cycle pulse for a new data_o
//   overflow_o  sticky lane buffer overflow
module ssio_ddr_in_deser
    import ssio_ddr_in_deser_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int RATIO = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [WIDTH-1:0]           ddr_i,
    input  logic                       sdr_mode_i,
    input  logic [WIDTH-1:0]           bitslip_i,
    output logic [WIDTH*2*RATIO-1:0]   data_o,
    output logic                       valid_o,
    output logic                       overflow_o
);

    localparam int W = word_w(RATIO);

    logic               mode_q;
    logic               mode_change;
    logic               emit;
    logic [WIDTH-1:0]   lane_ready;
    logic [WIDTH-1:0]   lane_ovf;
    logic [WIDTH*W-1:0] lane_words;

    // A mode change flushes every lane, so lane_ready is already low then;
    // gating emit keeps the intent explicit.
    assign mode_change = (sdr_mode_i != mode_q);
    assign emit        = (&lane_ready) & ~mode_change;

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        logic [1:0] pair;

        bsg_link_iddr_phy #(
            .width_p (1)
        ) u_iddr (
            .clk_i    (clk_i),
            .data_i   (ddr_i[n]),
            .data_r_o (pair)
        );

        ssio_ddr_lane_buf #(
            .RATIO (RATIO)
        ) u_buf (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .q1_i       (pair[0]),
            .q2_i       (pair[1]),
            .sdr_mode_i (sdr_mode_i),
            .bitslip_i  (bitslip_i[n]),
            .flush_i    (mode_change),
            .pop_i      (emit),
            .ready_o    (lane_ready[n]),
            .word_o     (lane_words[n*W +: W]),
            .ovf_o      (lane_ovf[n])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q     <= MODE_DDR;
            data_o     <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            mode_q     <= sdr_mode_i;
            valid_o    <= emit;
            overflow_o <= overflow_o | (|lane_ovf);
            if (emit) begin
                data_o <= lane_words;
            end
        end
    end

endmodule

// File: tb/tb_ssio_ddr_in_deser.sv
// tb/tb_ssio_ddr_in_deser.sv - scoreboard bench for the DDR input deserialiser
module tb_ssio_ddr_in_deser;

    localparam int WIDTH = 2;
    localparam int RATIO = 2;
    localparam int W     = 2 * RATIO;
    localparam int CAP   = 2 * W;

    typedef struct {
        logic [WIDTH*W-1:0] data;
        int                 cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_i = 1'b1;
    logic [WIDTH-1:0]   ddr_i = '0;
    logic               sdr_mode_i = 1'b0;
    logic [WIDTH-1:0]   bitslip_i = '0;
    logic [WIDTH*W-1:0] data_o;
    logic               valid_o;
    logic               overflow_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    exp_t               sb[$];
    exp_t               e_cur;
    logic [WIDTH*W-1:0] got[$];
    bit                 mq[WIDTH][$];
    bit                 m_ovf  = 1'b0;
    bit                 m_mode = 1'b0;

    ssio_ddr_in_deser #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .ddr_i      (ddr_i),
        .sdr_mode_i (sdr_mode_i),
        .bitslip_i  (bitslip_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference behaviour for one consumed pair, using per-lane bit queues.
    function automatic void model_step(input logic [1:0] rise, input logic [1:0] fall,
                                       input logic [1:0] slip, input logic sdr, input logic rst);
        bit                 b[$];
        logic [WIDTH*W-1:0] word;
        exp_t               e;
        if (rst) begin
            for (int n = 0; n < WIDTH; n++) mq[n].delete();
            m_ovf  = 1'b0;
            m_mode = 1'b0;
            return;
        end
        if (sdr != m_mode) begin
            m_mode = sdr;
            for (int n = 0; n < WIDTH; n++) mq[n].delete();
            return;
        end
        for (int n = 0; n < WIDTH; n++) begin
            b.delete();
            if (!sdr) begin
                if (!slip[n]) b.push_back(rise[n]);
                b.push_back(fall[n]);
            end else if (!slip[n]) begin
                b.push_back(rise[n]);
            end
            foreach (b[i]) begin
                if (mq[n].size() < CAP) mq[n].push_back(b[i]);
                else m_ovf = 1'b1;
            end
        end
        if (mq[0].size() >= W && mq[1].size() >= W) begin
            word = '0;
            for (int n = 0; n < WIDTH; n++)
                for (int i = 0; i < W; i++)
                    word[n*W+i] = mq[n].pop_front();
            e.data = word;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
    endfunction

    // Called just after a falling edge: rising bit before the next rising edge,
    // falling bit and the controls for this pair after it.
    task automatic drive_pair(input logic [1:0] rise, input logic [1:0] fall,
                              input logic [1:0] slip, input logic sdr, input logic rst);
        bit ovf_before;
        ddr_i = rise;
        @(posedge clk); #1;
        ddr_i      = fall;
        bitslip_i  = slip;
        sdr_mode_i = sdr;
        reset_i    = rst;
        ovf_before = m_ovf;
        model_step(rise, fall, slip, sdr, rst);
        @(negedge clk); #1;
        check_eq("overflow_track", overflow_o, ovf_before);
    endtask

    task automatic do_reset();
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        check_eq("rst_data", data_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_overflow", overflow_o, 0);
        check_eq("sb_drained", sb.size(), 0);
        got.delete();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e_cur = sb.pop_front();
            check_eq("valid_at", valid_o, 1);
            check_eq("word", data_o, e_cur.data);
            got.push_back(data_o);
        end else begin
            check_eq("valid_idle", valid_o, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH*W-1:0] w;
        logic               sdr_r;

        @(negedge clk); #1;
        do_reset();

        // DDR basic: lane0 1,0,1,1,0,0,1,0
        drive_pair(2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b11, 2'b01, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("ddr_n_words", got.size(), 2);
        w = got[0]; check_eq("ddr_word0_l0", w[3:0], 4'b1101);
        w = got[1]; check_eq("ddr_word1_l0", w[3:0], 4'b0100);
        do_reset();

        // SDR: switch pair, then lane0 rising 1,1,0,1, all falling bits 1
        drive_pair(2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b11, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b10, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
        check_eq("sdr_n_words", got.size(), 1);
        w = got[0]; check_eq("sdr_word_l0", w[3:0], 4'b1011);
        do_reset();

        // Bitslip on lane1 at the first pair; lane1 stream 0,1,1,0,1,0,1,1,0,0,1,0
        drive_pair(2'b01, 2'b11, 2'b10, 1'b0, 1'b0);
        drive_pair(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("slip_n_words", got.size(), 2);
        w = got[0]; check_eq("slip_word0_l1", w[7:4], 4'b1011);
        do_reset();

        // Overflow: lane1 slipped for 8 consecutive cycles
        for (int i = 0; i < 8; i++)
            drive_pair(2'($urandom), 2'($urandom), 2'b10, 1'b0, 1'b0);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("ovf_set", overflow_o, 1);
        for (int i = 0; i < 4; i++)
            drive_pair(2'($urandom), 2'($urandom), 2'b00, 1'b0, 1'b0);
        check_eq("ovf_sticky", overflow_o, 1);
        do_reset();

        // Mode switch mid-word
        drive_pair(2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b11, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b10, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        check_eq("switch_n_words", got.size(), 1);
        w = got[0]; check_eq("switch_word", w, 8'b1001_0110);
        do_reset();

        // Reset with lane0 holding 3 bits
        drive_pair(2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b11, 2'b11, 2'b01, 1'b0, 1'b0);
        do_reset();
        drive_pair(2'b11, 2'b10, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
        drive_pair(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        check_eq("postrst_n_words", got.size(), 1);
        w = got[0]; check_eq("postrst_word", w, 8'b0011_1001);
        do_reset();

        // Random traffic with slips and mode toggles
        sdr_r = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(9) == 0) sdr_r = ~sdr_r;
            drive_pair(2'($urandom), 2'($urandom),
                       {($urandom_range(3) == 0), ($urandom_range(3) == 0)}, sdr_r, 1'b0);
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
